// File: rtl/filtro_sensores.sv
// filtro_sensores: input conditioning ahead of the door-control FSM.
// Each of the four raw lines gets a two-flop synchroniser and a debouncer.
// The debounced levels are presented as {giro,entrada,saida,metais},
// together with registered one-cycle edge pulses.
module filtro_sensores #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       giro_in,
    input  logic       entrada_in,
    input  logic       saida_in,
    input  logic       metais_in,
    output logic [3:0] sensores,
    output logic [3:0] subida,
    output logic [3:0] descida,
    output logic       mudou
);

    localparam int unsigned NCH     = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0] pins;
    logic [NCH-1:0] s1;
    logic [NCH-1:0] s;
    logic [NCH-1:0] q;
    logic [NCH-1:0] done_c;
    logic [CNT_W-1:0] cnt     [NCH];
    logic [CNT_W-1:0] cnt_nxt [NCH];

    // Channel order matches the bit order decoded by the downstream FSM.
    assign pins     = {giro_in, entrada_in, saida_in, metais_in};
    assign sensores = q;

    // Two-flop synchroniser, no logic between the stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s  <= '0;
        end else begin
            s1 <= pins;
            s  <= s1;
        end
    end

    // Debounce decision: restart on agreement, accept once the count saturates.
    always_comb begin
        done_c = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt[i] = '0;
            if (s[i] != q[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    done_c[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Counters, accepted levels and edge pulses, all updated together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
            q       <= '0;
            subida  <= '0;
            descida <= '0;
            mudou   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            q       <= q ^ done_c;
            subida  <= done_c & s;
            descida <= done_c & ~s;
            mudou   <= |done_c;
        end
    end

endmodule
